// File: rtl/uart_tx.sv
// UART serialiser: start bit, DATA_BITS data bits LSB-first, optional parity, STOP_BITS stop bits.
// Bit timing comes from an external baud divider whose enable this block owns.
module uart_tx #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 baud_tick_in,
    output logic                 baud_en_out,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    output logic                 tx_out,
    output logic                 busy_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_e;

    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    state_e               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 tx_q, tx_d;

    always_comb begin
        // NOTE: every next-state signal gets a hold default first so no path infers a latch.
        state_d    = state_q;
        shift_d    = shift_q;
        par_d      = par_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx_q;

        unique case (state_q)
            S_IDLE: begin
                if (valid_in) begin
                    shift_d = data_in;
                    par_d   = (PARITY == 1) ? ~^data_in : ^data_in;
                    state_d = S_SYNC;
                end
            end
            S_SYNC: begin
                if (baud_tick_in) begin
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_tick_in) begin
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = 3'd0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_tick_in) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        if (PARITY != 0) begin
                            tx_d    = par_q;
                            state_d = S_PAR;
                        end else begin
                            tx_d       = 1'b1;
                            stop_cnt_d = 1'b0;
                            state_d    = S_STOP;
                        end
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            S_PAR: begin
                if (baud_tick_in) begin
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = S_STOP;
                end
            end
            S_STOP: begin
                if (baud_tick_in) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        state_d = S_IDLE;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst_in) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            par_q      <= 1'b0;
            bit_cnt_q  <= 3'd0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
        end
    end

    // Handshake and divider enable decode straight from the state register.
    assign tx_out      = tx_q;
    assign ready_out   = (state_q == S_IDLE);
    assign busy_out    = (state_q != S_IDLE);
    assign baud_en_out = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four configurations (8N1, 8O1, 8E1, 5N2), each behind its own baud divider,
// checked every cycle against a frame-level waveform model plus hand-computed literals.
module tb_uart_tx;

    localparam int PER   [4] = '{4, 4, 4, 3};
    localparam int DBITS [4] = '{8, 8, 8, 5};
    localparam int PARM  [4] = '{0, 1, 2, 0};
    localparam int STOPS [4] = '{1, 1, 1, 2};

    typedef struct packed {
        logic tx;
        logic rdy;
    } exp_t;

    localparam exp_t IDLE_EXP = '{tx: 1'b1, rdy: 1'b1};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_force = 1'b0;
    logic [3:0] valid = 4'b0;
    logic [7:0] data [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    wire  [3:0] tx_w, ready_w, busy_w, en_w, tick_w;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;
    logic chk_en = 1'b0;
    exp_t exp_q [4][$];

    int         dcnt [4];
    logic [3:0] dpulse;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Baud divider model: counter held clear while disabled, one-cycle pulse every PER cycles.
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rst || !en_w[k]) begin
                dcnt[k]   <= 0;
                dpulse[k] <= 1'b0;
            end else begin
                dpulse[k] <= (dcnt[k] == 0);
                dcnt[k]   <= (dcnt[k] == PER[k] - 1) ? 0 : dcnt[k] + 1;
            end
        end
    end
    assign tick_w = dpulse | {4{tick_force}};

    uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk_in(clk), .rst_in(rst), .baud_tick_in(tick_w[0]), .baud_en_out(en_w[0]),
        .data_in(data[0]), .valid_in(valid[0]), .ready_out(ready_w[0]),
        .tx_out(tx_w[0]), .busy_out(busy_w[0]));

    uart_tx #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
        .clk_in(clk), .rst_in(rst), .baud_tick_in(tick_w[1]), .baud_en_out(en_w[1]),
        .data_in(data[1]), .valid_in(valid[1]), .ready_out(ready_w[1]),
        .tx_out(tx_w[1]), .busy_out(busy_w[1]));

    uart_tx #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .clk_in(clk), .rst_in(rst), .baud_tick_in(tick_w[2]), .baud_en_out(en_w[2]),
        .data_in(data[2]), .valid_in(valid[2]), .ready_out(ready_w[2]),
        .tx_out(tx_w[2]), .busy_out(busy_w[2]));

    uart_tx #(.DATA_BITS(5), .PARITY(0), .STOP_BITS(2)) u_5n2 (
        .clk_in(clk), .rst_in(rst), .baud_tick_in(tick_w[3]), .baud_en_out(en_w[3]),
        .data_in(data[3][4:0]), .valid_in(valid[3]), .ready_out(ready_w[3]),
        .tx_out(tx_w[3]), .busy_out(busy_w[3]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s timed out (cycle %0d)", name, cyc);
    endtask

    // Frame model: line levels per bit, each held PER cycles, after a two-cycle divider start-up.
    task automatic push_frame(input int k, input logic [7:0] b);
        logic bits[$];
        int   ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < DBITS[k]; i++) begin
            bits.push_back(b[i]);
            ones += int'(b[i]);
        end
        if (PARM[k] == 1) bits.push_back((ones % 2 == 0) ? 1'b1 : 1'b0);
        else if (PARM[k] == 2) bits.push_back((ones % 2 == 1) ? 1'b1 : 1'b0);
        for (int s = 0; s < STOPS[k]; s++) bits.push_back(1'b1);
        repeat (2) exp_q[k].push_back('{tx: 1'b1, rdy: 1'b0});
        foreach (bits[i]) repeat (PER[k]) exp_q[k].push_back('{tx: bits[i], rdy: 1'b0});
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 4; k++) begin
                exp_t e;
                if (exp_q[k].size() != 0) e = exp_q[k].pop_front();
                else e = IDLE_EXP;
                check($sformatf("u%0d_tx", k), 32'(tx_w[k]), 32'(e.tx));
                check($sformatf("u%0d_ready", k), 32'(ready_w[k]), 32'(e.rdy));
                check($sformatf("u%0d_busy", k), 32'(busy_w[k]), 32'(!e.rdy));
                check($sformatf("u%0d_baud_en", k), 32'(en_w[k]), 32'(!e.rdy));
            end
        end
    end

    // Drives one byte and returns the accept edge index; called at posedge+1.
    task automatic send(input int k, input logic [7:0] b, input bit do_push, input bit hold,
                        output int acc);
        logic r;
        int   n = 0;
        acc = -1;
        data[k]  = b;
        valid[k] = 1'b1;
        forever begin
            r = ready_w[k];
            @(posedge clk);
            #1;
            if (r === 1'b1) begin
                acc = cyc;
                if (do_push) push_frame(k, b);
                if (!hold) valid[k] = 1'b0;
                return;
            end
            if (++n > 200) begin
                timeout($sformatf("u%0d_accept", k));
                valid[k] = 1'b0;
                return;
            end
        end
    endtask

    // Waits on negedges until tx (sel=0) or ready (sel=1) reaches v; returns the edge index.
    task automatic wait_sig(input int k, input bit sel, input logic v, output int at);
        at = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if ((sel ? ready_w[k] : tx_w[k]) === v) begin
                at = cyc;
                return;
            end
        end
        timeout($sformatf("u%0d_%s_to_%0d", k, sel ? "ready" : "tx", v));
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic idle_gap();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int acc, fall, rdy, r, f, e, a2;
        logic [9:0] pat_55;
        logic [7:0] pat_1f;
        pat_55 = 10'h2AA;
        pat_1f = 8'hFE;

        // Reset held two cycles, with a forced tick that must be ignored.
        rst = 1'b1;
        @(posedge clk);
        #1 tick_force = 1'b1;
        @(posedge clk);
        #1 tick_force = 1'b0;
        rst    = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_tx", 32'(tx_w[0]), 32'd1);
        check("rst_ready", 32'(ready_w[0]), 32'd1);
        check("rst_busy", 32'(busy_w[0]), 32'd0);
        check("rst_baud_en", 32'(en_w[0]), 32'd0);
        @(posedge clk);
        #1 tick_force = 1'b1;
        repeat (3) @(posedge clk);
        #1 tick_force = 1'b0;
        @(negedge clk);
        check("idle_tick_tx", 32'(tx_w[0]), 32'd1);
        check("idle_tick_ready", 32'(ready_w[0]), 32'd1);
        idle_gap();

        // 8N1, P=4, 0x55.
        send(0, 8'h55, 1'b1, 1'b0, acc);
        wait_sig(0, 1'b0, 1'b0, fall);
        check("8n1_start_latency", 32'(fall - acc), 32'd2);
        for (int i = 0; i < 10; i++) begin
            wait_cyc(fall + i * 4 + 1);
            check($sformatf("8n1_bit%0d", i), 32'(tx_w[0]), 32'(pat_55[i]));
        end
        wait_sig(0, 1'b1, 1'b1, rdy);
        check("8n1_frame_len", 32'(rdy - fall), 32'd40);
        idle_gap();

        // Parity: 0x01 odd -> 0, 0x01 even -> 1, 0xA5 even -> 0.
        send(1, 8'h01, 1'b1, 1'b0, acc);
        wait_sig(1, 1'b0, 1'b0, fall);
        wait_cyc(fall + 9 * 4 + 1);
        check("odd_01_parity", 32'(tx_w[1]), 32'd0);
        wait_sig(1, 1'b1, 1'b1, rdy);
        check("odd_frame_len", 32'(rdy - fall), 32'd44);
        idle_gap();

        send(2, 8'h01, 1'b1, 1'b0, acc);
        wait_sig(2, 1'b0, 1'b0, fall);
        wait_cyc(fall + 9 * 4 + 1);
        check("even_01_parity", 32'(tx_w[2]), 32'd1);
        wait_sig(2, 1'b1, 1'b1, rdy);
        check("even_frame_len", 32'(rdy - fall), 32'd44);
        idle_gap();

        send(2, 8'hA5, 1'b1, 1'b0, acc);
        wait_sig(2, 1'b0, 1'b0, fall);
        wait_cyc(fall + 9 * 4 + 1);
        check("even_a5_parity", 32'(tx_w[2]), 32'd0);
        wait_sig(2, 1'b1, 1'b1, rdy);
        idle_gap();

        // 5 data bits, 2 stop bits, P=3, 0x1F.
        send(3, 8'h1F, 1'b1, 1'b0, acc);
        wait_sig(3, 1'b0, 1'b0, fall);
        for (int i = 0; i < 8; i++) begin
            wait_cyc(fall + i * 3 + 1);
            check($sformatf("5n2_bit%0d", i), 32'(tx_w[3]), 32'(pat_1f[i]));
        end
        wait_sig(3, 1'b1, 1'b1, rdy);
        check("5n2_frame_len", 32'(rdy - fall), 32'd24);
        idle_gap();

        // Back-to-back 0x00 then 0xFF, with 0x3C pulses while busy.
        send(0, 8'h00, 1'b1, 1'b1, acc);
        push_frame(0, 8'h00);
        exp_q[0].delete();
        push_frame(0, 8'h00);
        exp_q[0].push_back(IDLE_EXP);
        push_frame(0, 8'hFF);
        fork
            begin
                valid[0] = 1'b0;
                for (int i = 0; i < 12; i++) begin
                    @(posedge clk);
                    #1;
                    data[0]  = 8'h3C;
                    valid[0] = i[0];
                end
                repeat (10) @(posedge clk);
                #1;
                data[0]  = 8'hFF;
                valid[0] = 1'b1;
                while (cyc < acc + 50) begin
                    @(posedge clk);
                    #1;
                end
                valid[0] = 1'b0;
            end
            begin
                wait_sig(0, 1'b0, 1'b0, fall);
                wait_sig(0, 1'b0, 1'b1, r);
                wait_sig(0, 1'b0, 1'b0, f);
                check("b2b_gap_stop_len", 32'(f - r), 32'd7);
            end
            begin
                wait_sig(0, 1'b1, 1'b1, e);
                wait_sig(0, 1'b1, 1'b0, a2);
                check("b2b_accept_delay", 32'(a2 - e), 32'd1);
                check("b2b_first_len", 32'(e - fall), 32'd40);
            end
        join
        wait_sig(0, 1'b1, 1'b1, rdy);
        check("b2b_second_len", 32'(rdy - f), 32'd40);
        idle_gap();

        // Reset during data bit 3, then a clean 0x81 frame.
        send(0, 8'h0F, 1'b1, 1'b0, acc);
        wait_sig(0, 1'b0, 1'b0, fall);
        wait_cyc(fall + 4 * 4 + 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q[0].delete();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_tx", 32'(tx_w[0]), 32'd1);
        check("midrst_baud_en", 32'(en_w[0]), 32'd0);
        check("midrst_ready", 32'(ready_w[0]), 32'd1);
        idle_gap();

        send(0, 8'h81, 1'b1, 1'b0, acc);
        wait_sig(0, 1'b0, 1'b0, fall);
        check("post_rst_latency", 32'(fall - acc), 32'd2);
        wait_sig(0, 1'b1, 1'b1, rdy);
        check("post_rst_len", 32'(rdy - fall), 32'd40);
        idle_gap();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART serialiser that sits directly downstream of the `div` baud divider. It accepts one byte per valid/ready handshake and shifts it out LSB-first as a framed serial stream: start bit, 5–8 data bits, optional parity, and 1 or 2 stop bits. The bit timing comes only from the divider's one-cycle `pulse_out`. The block owns the divider's `clk_en`, so every frame starts phase-aligned to a fresh divider period.

## Interface
- `DATA_BITS`, default 8: data bits per frame. Legal range 5..8.
- `PARITY`, default 0: parity mode. 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: stop bits per frame. Legal values 1 or 2.
- `clk_in`, input, 1: single system clock. All logic is on its rising edge.
- `rst_in`, input, 1: reset, synchronous, active-high.
- `baud_tick_in`, input, 1: one-cycle bit-boundary pulse, connected to `div.pulse_out`.
- `baud_en_out`, output, 1: connected to `div.clk_en`. High from frame acceptance until the end of the last stop bit.
- `data_in`, input, DATA_BITS: byte to send. Sampled only on the accept edge.
- `valid_in`, input, 1: `data_in` is valid.
- `ready_out`, output, 1: the block can accept a byte. High only in IDLE.
- `tx_out`, output, 1: serial line. Idles high. Registered, glitch-free.
- `busy_out`, output, 1: high in every state other than IDLE.

## Operation
- Reset values: state = IDLE, `tx_out` = 1, `ready_out` = 1, `busy_out` = 0, `baud_en_out` = 0, bit and stop counters = 0.
- Accept condition: `valid_in && ready_out` on a rising edge.
  - Latch `data_in` into the shift register.
  - Latch the parity bit. Odd mode sets it to ~^data; even mode sets it to ^data.
  - Next state is SYNC, with `ready_out` = 0 and `baud_en_out` = 1.
- `baud_tick_in` is ignored in IDLE. Every other state holds until a tick arrives.
- SYNC: on tick, set `tx_out` = 0 (start bit begins) and go to START.
- START: on tick, set `tx_out` = shift[0], shift the register right, set bit_cnt = 0, and go to DATA.
- DATA: on tick:
  - If bit_cnt == DATA_BITS-1: if PARITY != 0, drive the parity bit and go to PAR. Otherwise set `tx_out` = 1, stop_cnt = 0, and go to STOP.
  - Otherwise drive the next data bit and increment bit_cnt.
- PAR: on tick, set `tx_out` = 1, stop_cnt = 0, and go to STOP.
- STOP: on tick:
  - If stop_cnt == STOP_BITS-1: go to IDLE with `ready_out` = 1 and `baud_en_out` = 0. `tx_out` stays 1.
  - Otherwise increment stop_cnt.
- `valid_in` is ignored while busy. There is no queuing.
- `data_in` changes after the accept edge have no effect on the frame in flight.
- Counter widths: bit_cnt is 3 bits. stop_cnt is 1 bit.
- Reset asserted mid-frame: on the next edge the block returns to the reset values. This forces `tx_out` high immediately, which truncates the frame, and drops `baud_en_out`, which rearms the divider.
- A tick and `rst_in` on the same edge: reset wins.

## Timing
With `div` wired in and divider period P ≥ 2:
- Accept edge A: `baud_en_out` rises after A.
  - The divider pulses after A+1.
  - SYNC sees the tick at A+2, so `tx_out` falls after edge A+2.
- Every bit, including each stop bit, lasts exactly P cycles.
- Frame length from the start-bit falling edge to the IDLE return is (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) × P cycles.
- `ready_out` rises on the edge that ends the last stop bit.
- Back-to-back frames, with `valid_in` held high:
  - Acceptance happens 1 cycle after the IDLE return.
  - The next start bit falls 3 cycles after the IDLE return.
  - The final stop bit therefore measures P+3 cycles on the line.
- Handshake latency: `ready_out` drops on the edge after acceptance. The transfer occurs on exactly one edge.

## Test plan
- Reset: hold `rst_in` for 2 cycles → `tx_out` = 1, `ready_out` = 1, `busy_out` = 0, `baud_en_out` = 0. No ticks are consumed.
- 8N1, P=4, send 0x55:
  - `tx_out` falls 2 cycles after acceptance.
  - Line pattern, each level held 4 cycles: 0, 1,0,1,0,1,0,1,0, 1.
  - `ready_out` returns 40 cycles after the start-bit fall.
- Parity, P=4, 8 data bits:
  - 0x01 with odd parity → parity bit 0.
  - 0x01 with even parity → parity bit 1.
  - 0xA5 with even parity → parity bit 0.
  - Frame length is 44 cycles.
- DATA_BITS=5, STOP_BITS=2, P=3, send 0x1F:
  - Line pattern: 0, 1,1,1,1,1, 1,1.
  - Both stop bits are 3 cycles each, 24 cycles total.
- Back-to-back 0x00 then 0xFF with `valid_in` held high:
  - The second byte is accepted 1 cycle after the IDLE return.
  - The gap stop bit measures P+3 cycles.
  - While busy, `valid_in` pulsing with 0x3C is not accepted and does not alter the frame.
- Reset mid-frame during data bit 3:
  - `tx_out` = 1 and `baud_en_out` = 0 on the next edge.
  - A following send of 0x81 produces a correct, full-length frame.
